// File: rtl/regfile_sequencer.sv
// Serializes a two-read/one-write register-file request onto a single shared RF port.
// Optional macro REGSEQ_ZERO_REG_EN: address 0 reads as zero and writes to it are dropped.
module regfile_sequencer #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_rs,
    input  logic [ADDR_W-1:0] req_rt,
    input  logic [ADDR_W-1:0] req_rd,
    input  logic              req_we,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rs_data,
    output logic [DATA_W-1:0] rsp_rt_data,
    output logic              rsp_err,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_addr,
    output logic [DATA_W-1:0] rf_din,
    input  logic [DATA_W-1:0] rf_dout
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] RD_RS = 3'd1;
    localparam logic [2:0] RD_RT = 3'd2;
    localparam logic [2:0] WR    = 3'd3;
    localparam logic [2:0] RESP  = 3'd4;

    logic [2:0]        state_reg, state_next;
    logic [ADDR_W-1:0] rs_reg, rt_reg, rd_reg;
    logic              we_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic [DATA_W-1:0] rs_data_reg, rt_data_reg;
    logic              err_reg;
    logic              accept;
    logic              wr_ok;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return 32'(a) < NUM_REGS;
    endfunction

    // Addresses whose read value is forced to zero instead of taken from rf_dout.
    function automatic logic read_as_zero(input logic [ADDR_W-1:0] a);
`ifdef REGSEQ_ZERO_REG_EN
        return !in_range(a) || (a == '0);
`else
        return !in_range(a);
`endif
    endfunction

`ifdef REGSEQ_ZERO_REG_EN
    assign wr_ok = we_reg && in_range(rd_reg) && (rd_reg != '0);
`else
    assign wr_ok = we_reg && in_range(rd_reg);
`endif

    assign req_ready   = (state_reg == IDLE) && !reset;
    assign accept      = req_valid && req_ready;
    assign rsp_valid   = (state_reg == RESP);
    assign rsp_rs_data = rs_data_reg;
    assign rsp_rt_data = rt_data_reg;
    assign rsp_err     = err_reg;

    always_comb begin
        state_next = state_reg;
        rf_addr    = '0;
        rf_din     = '0;
        rf_we      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (accept) state_next = RD_RS;
            end
            RD_RS: begin
                rf_addr    = rs_reg;
                state_next = RD_RT;
            end
            RD_RT: begin
                rf_addr    = rt_reg;
                state_next = WR;
            end
            WR: begin
                // WR always takes one cycle so latency never depends on the request.
                if (wr_ok) begin
                    rf_addr = rd_reg;
                    rf_din  = wdata_reg;
                    rf_we   = !reset;
                end
                state_next = RESP;
            end
            RESP: begin
                if (rsp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            rs_reg      <= '0;
            rt_reg      <= '0;
            rd_reg      <= '0;
            we_reg      <= 1'b0;
            wdata_reg   <= '0;
            rs_data_reg <= '0;
            rt_data_reg <= '0;
            err_reg     <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        rs_reg      <= req_rs;
                        rt_reg      <= req_rt;
                        rd_reg      <= req_rd;
                        we_reg      <= req_we;
                        wdata_reg   <= req_wdata;
                        rs_data_reg <= '0;
                        rt_data_reg <= '0;
                        err_reg     <= 1'b0;
                    end
                end
                RD_RS: begin
                    rs_data_reg <= read_as_zero(rs_reg) ? '0 : rf_dout;
                    if (!in_range(rs_reg)) err_reg <= 1'b1;
                end
                RD_RT: begin
                    rt_data_reg <= read_as_zero(rt_reg) ? '0 : rf_dout;
                    if (!in_range(rt_reg)) err_reg <= 1'b1;
                end
                WR: begin
                    if (we_reg && !in_range(rd_reg)) err_reg <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_sequencer.sv
// Self-checking bench for regfile_sequencer: directed table, reset/zero-register sequences, random traffic.
module tb_regfile_sequencer;
    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready;
    logic [4:0]  req_rs, req_rt, req_rd;
    logic        req_we;
    logic [31:0] req_wdata;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_rs_data, rsp_rt_data;
    logic        rsp_err;
    logic        rf_we;
    logic [4:0]  rf_addr;
    logic [31:0] rf_din, rf_dout;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    regfile_sequencer #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(16)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd),
        .req_we(req_we), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rs_data(rsp_rs_data), .rsp_rt_data(rsp_rt_data), .rsp_err(rsp_err),
        .rf_we(rf_we), .rf_addr(rf_addr), .rf_din(rf_din), .rf_dout(rf_dout)
    );

    // Register-file environment: 32 locations, async read, sync write.
    logic [31:0] mem [0:31];
    logic        mem_loaded = 1'b0;
    int          wr_cnt = 0;
    logic [4:0]  wr_addr;
    logic [31:0] wr_din;

    assign rf_dout = mem[rf_addr];

    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 32; i++) mem[i] <= 32'h1000_0000 + 32'(i);
            mem_loaded <= 1'b1;
        end else if (rf_we) begin
            mem[rf_addr] <= rf_din;
            wr_cnt       <= wr_cnt + 1;
            wr_addr      <= rf_addr;
            wr_din       <= rf_din;
        end
    end

    // Reference model of the architectural registers.
    logic [31:0] model_regs [0:15];

    function automatic logic [31:0] model_read(input logic [4:0] a);
        if (a >= 5'd16) return 32'h0;
`ifdef REGSEQ_ZERO_REG_EN
        if (a == 5'd0) return 32'h0;
`endif
        return model_regs[a[3:0]];
    endfunction

    function automatic int model_writes(input logic [4:0] rd, input logic we);
        if (!we || rd >= 5'd16) return 0;
`ifdef REGSEQ_ZERO_REG_EN
        if (rd == 5'd0) return 0;
`endif
        return 1;
    endfunction

    task automatic model_commit(input logic [4:0] rd, input logic we, input logic [31:0] wd);
        if (model_writes(rd, we) == 1) model_regs[rd[3:0]] = wd;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // One complete transaction; called just after a falling edge, returns just after one.
    task automatic do_txn(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                          input logic we, input logic [31:0] wd,
                          input logic [31:0] ers, input logic [31:0] ert, input logic eerr,
                          input int ewr, input int hold, input string tag);
        int cnt;
        int w0;
        req_rs = rs; req_rt = rt; req_rd = rd; req_we = we; req_wdata = wd;
        req_valid = 1'b1;
        cnt = 0;
        while (!req_ready && cnt < 20) begin @(negedge clk); cnt++; end
        chk({tag, " req_ready"}, {31'h0, req_ready}, 32'h1);
        w0 = wr_cnt;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk({tag, " rd_rs addr"}, {27'h0, rf_addr}, {27'h0, rs});
        chk({tag, " err cleared"}, {31'h0, rsp_err}, 32'h0);
        chk({tag, " valid early1"}, {31'h0, rsp_valid}, 32'h0);
        @(negedge clk);
        chk({tag, " rd_rt addr"}, {27'h0, rf_addr}, {27'h0, rt});
        chk({tag, " valid early2"}, {31'h0, rsp_valid}, 32'h0);
        @(negedge clk);
        chk({tag, " wr we"}, {31'h0, rf_we}, 32'(ewr));
        cnt = 3;
        while (!rsp_valid && cnt < 12) begin @(negedge clk); cnt++; end
        chk({tag, " latency"}, 32'(cnt), 32'd4);
        chk({tag, " rs_data"}, rsp_rs_data, ers);
        chk({tag, " rt_data"}, rsp_rt_data, ert);
        chk({tag, " err"}, {31'h0, rsp_err}, {31'h0, eerr});
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk({tag, " hold valid"}, {31'h0, rsp_valid}, 32'h1);
            chk({tag, " hold ready"}, {31'h0, req_ready}, 32'h0);
            chk({tag, " hold rs"}, rsp_rs_data, ers);
            chk({tag, " hold rt"}, rsp_rt_data, ert);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        chk({tag, " done valid"}, {31'h0, rsp_valid}, 32'h0);
        chk({tag, " done idle"}, {31'h0, req_ready}, 32'h1);
        chk({tag, " wr count"}, 32'(wr_cnt - w0), 32'(ewr));
        if (ewr == 1) begin
            chk({tag, " wr addr"}, {27'h0, wr_addr}, {27'h0, rd});
            chk({tag, " wr data"}, wr_din, wd);
        end
        $display("txn %s rs=%0d rt=%0d rd=%0d we=%0d wd=%h -> rs_data=%h rt_data=%h err=%0d",
                 tag, rs, rt, rd, we, wd, rsp_rs_data, rsp_rt_data, rsp_err);
    endtask

    typedef struct {
        logic [4:0]  rs, rt, rd;
        logic        we;
        logic [31:0] wd, ers, ert;
        logic        eerr;
        int          ewr;
    } vec_t;

    vec_t vt [9];

    initial begin
        int w0;
        logic [4:0]  rs, rt, rd;
        logic        we, eerr;
        logic [31:0] wd;

        for (int i = 0; i < 16; i++) model_regs[i] = 32'h1000_0000 + 32'(i);
        vt[0] = '{5'd1,  5'd2,  5'd3,  1'b1, 32'hDEADBEEF, 32'h10000001, 32'h10000002, 1'b0, 1};
        vt[1] = '{5'd3,  5'd3,  5'd9,  1'b0, 32'h0,        32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 0};
        vt[2] = '{5'd4,  5'd4,  5'd5,  1'b1, 32'h11,       32'h10000004, 32'h10000004, 1'b0, 1};
        vt[3] = '{5'd5,  5'd5,  5'd5,  1'b1, 32'h22,       32'h11,       32'h11,       1'b0, 1};
        vt[4] = '{5'd5,  5'd5,  5'd1,  1'b0, 32'h0,        32'h22,       32'h22,       1'b0, 0};
        vt[5] = '{5'd20, 5'd2,  5'd17, 1'b1, 32'h99,       32'h0,        32'h10000002, 1'b1, 0};
        vt[6] = '{5'd15, 5'd16, 5'd31, 1'b0, 32'h0,        32'h1000000F, 32'h0,        1'b1, 0};
        vt[7] = '{5'd1,  5'd1,  5'd16, 1'b0, 32'h0,        32'h10000001, 32'h10000001, 1'b0, 0};
        vt[8] = '{5'd15, 5'd3,  5'd15, 1'b1, 32'hCAFE,     32'h1000000F, 32'hDEADBEEF, 1'b0, 1};

        reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
        req_rs = '0; req_rt = '0; req_rd = '0; req_we = 1'b0; req_wdata = '0;
        repeat (3) @(negedge clk);
        chk("reset req_ready", {31'h0, req_ready}, 32'h0);
        chk("reset rsp_valid", {31'h0, rsp_valid}, 32'h0);
        chk("reset rf_we", {31'h0, rf_we}, 32'h0);
        chk("reset rf_addr", {27'h0, rf_addr}, 32'h0);
        chk("reset rsp_err", {31'h0, rsp_err}, 32'h0);
        chk("reset rs_data", rsp_rs_data, 32'h0);
        reset = 1'b0;
        @(negedge clk);
        chk("post reset req_ready", {31'h0, req_ready}, 32'h1);

        for (int i = 0; i < 9; i++) begin
            do_txn(vt[i].rs, vt[i].rt, vt[i].rd, vt[i].we, vt[i].wd,
                   vt[i].ers, vt[i].ert, vt[i].eerr, vt[i].ewr,
                   (i == 1) ? 10 : i % 3, $sformatf("vec%0d", i));
            model_commit(vt[i].rd, vt[i].we, vt[i].wd);
        end

        // Reset lands in the WR cycle of a write to r7.
        req_rs = 5'd1; req_rt = 5'd2; req_rd = 5'd7; req_we = 1'b1; req_wdata = 32'h55;
        req_valid = 1'b1;
        w0 = wr_cnt;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst wr before", {31'h0, rf_we}, 32'h1);
        chk("rst wr addr", {27'h0, rf_addr}, 32'd7);
        reset = 1'b1;
        #1;
        chk("rst wr suppressed", {31'h0, rf_we}, 32'h0);
        @(posedge clk);
        @(negedge clk);
        chk("rst rsp_valid", {31'h0, rsp_valid}, 32'h0);
        chk("rst req_ready", {31'h0, req_ready}, 32'h0);
        chk("rst rf_we", {31'h0, rf_we}, 32'h0);
        chk("rst rf_addr", {27'h0, rf_addr}, 32'h0);
        chk("rst rf_din", rf_din, 32'h0);
        chk("rst rs_data", rsp_rs_data, 32'h0);
        chk("rst rt_data", rsp_rt_data, 32'h0);
        chk("rst err", {31'h0, rsp_err}, 32'h0);
        chk("rst wr count", 32'(wr_cnt - w0), 32'h0);
        reset = 1'b0;
        #1;
        chk("rst release ready", {31'h0, req_ready}, 32'h1);
        @(negedge clk);
        do_txn(5'd7, 5'd7, 5'd0, 1'b0, 32'h0, 32'h10000007, 32'h10000007, 1'b0, 0, 1, "r7 unchanged");

        // Register 0 handling.
`ifdef REGSEQ_ZERO_REG_EN
        do_txn(5'd1, 5'd2, 5'd0, 1'b1, 32'hFF, 32'h10000001, 32'h10000002, 1'b0, 0, 0, "zero wr");
        model_commit(5'd0, 1'b1, 32'hFF);
        do_txn(5'd0, 5'd0, 5'd1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 0, 0, "zero rd");
`else
        do_txn(5'd1, 5'd2, 5'd0, 1'b1, 32'hFF, 32'h10000001, 32'h10000002, 1'b0, 1, 0, "zero wr");
        model_commit(5'd0, 1'b1, 32'hFF);
        do_txn(5'd0, 5'd0, 5'd1, 1'b0, 32'h0, 32'hFF, 32'hFF, 1'b0, 0, 0, "zero rd");
`endif

        for (int n = 0; n < 40; n++) begin
            rs = 5'($urandom_range(0, 19));
            rt = 5'($urandom_range(0, 19));
            rd = 5'($urandom_range(0, 19));
            we = 1'($urandom_range(0, 1));
            wd = $urandom;
            eerr = (rs >= 5'd16) || (rt >= 5'd16) || (we && rd >= 5'd16);
            do_txn(rs, rt, rd, we, wd, model_read(rs), model_read(rt), eerr,
                   model_writes(rd, we), int'($urandom_range(0, 3)), $sformatf("rnd%0d", n));
            model_commit(rd, we, wd);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
